// File: rtl/rt_ray_sequencer_pkg.sv
// Shared raytracer definitions: fixed-point format, 3-vector type, sequencer
// state encoding and small arithmetic helpers.
package rt_ray_sequencer_pkg;

    localparam int FP_IW = 16;
    localparam int FP_QW = 16;
    localparam int FP_WL = FP_IW + FP_QW;
    // Pixel counters must fit below the fixed-point sign bit.
    localparam int CNT_W = FP_IW - 1;

    typedef logic signed [FP_WL-1:0] fp_t;
    typedef fp_t [2:0] vec3_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_e;

    function automatic fp_t fp_mul(input fp_t a, input fp_t b);
        logic signed [2*FP_WL-1:0] prod;
        prod = (2*FP_WL)'(a) * (2*FP_WL)'(b);
        return prod[FP_QW +: FP_WL];
    endfunction

    function automatic int px_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/rt_ray_sequencer_if.sv
// Ray stream handshake between the sequencer (master) and its consumer (slave).
interface rt_ray_sequencer_if #(
    parameter int PX_W = 1
);
    import rt_ray_sequencer_pkg::*;

    logic            ray_valid_o;
    logic            ray_ready_i;
    vec3_t           ray_origin_o;
    vec3_t           ray_dir_o;
    logic [PX_W-1:0] ray_px_o;
    logic            ray_last_o;

    modport master (
        output ray_valid_o, ray_origin_o, ray_dir_o, ray_px_o, ray_last_o,
        input  ray_ready_i
    );

    modport slave (
        input  ray_valid_o, ray_origin_o, ray_dir_o, ray_px_o, ray_last_o,
        output ray_ready_i
    );
endinterface

// File: rtl/rt_ray_sequencer_rgu.sv
// rt_rgu: combinational ray generation unit; dir = p00 + x*du + y*dv - center,
// origin = center.
module rt_rgu
    import rt_ray_sequencer_pkg::*;
(
    input  vec3_t            pixel_00_loc,
    input  vec3_t            pixel_delta_u,
    input  vec3_t            pixel_delta_v,
    input  vec3_t            camera_center,
    input  logic [CNT_W-1:0] x,
    input  logic [CNT_W-1:0] y,
    output vec3_t            ray_origin,
    output vec3_t            ray_dir
);
    localparam int PAD_W = FP_WL - FP_QW - CNT_W;

    fp_t x_fp_s;
    fp_t y_fp_s;

    // Integer pixel coordinates promoted to fixed point, then the pixel-centre arithmetic.
    always_comb begin
        x_fp_s     = {{PAD_W{1'b0}}, x, {FP_QW{1'b0}}};
        y_fp_s     = {{PAD_W{1'b0}}, y, {FP_QW{1'b0}}};
        ray_origin = camera_center;
        ray_dir    = '0;
        for (int i = 0; i < 3; i++) begin
            ray_dir[i] = pixel_00_loc[i]
                       + fp_mul(x_fp_s, pixel_delta_u[i])
                       + fp_mul(y_fp_s, pixel_delta_v[i])
                       - camera_center[i];
        end
    end
endmodule

// File: rtl/rt_ray_sequencer.sv
// Frame sequencer: scans pixels row-major and streams one camera ray per pixel.
// Optional RT_SEQ_PERF_EN adds busy-cycle and stall performance counters.
module rt_ray_sequencer
    import rt_ray_sequencer_pkg::*;
#(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  start_i,
    input  logic  abort_i,
    input  vec3_t pixel_00_loc_i,
    input  vec3_t pixel_delta_u_i,
    input  vec3_t pixel_delta_v_i,
    input  vec3_t camera_center_i,
    output logic  busy_o,
    output logic  done_o,
    rt_ray_sequencer_if.master ray_if
`ifdef RT_SEQ_PERF_EN
    ,
    output logic [31:0] perf_cycles_o,
    output logic [31:0] perf_stalls_o
`endif
);
    localparam int PX_W = px_width(IMG_W * IMG_H);
    localparam longint unsigned CNT_LIM = 64'd1 << CNT_W;
    localparam logic [CNT_W-1:0] X_MAX = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] Y_MAX = CNT_W'(IMG_H - 1);

    if ((IMG_W < 1) || (64'(IMG_W) > CNT_LIM)) begin : g_bad_img_w
        $error("IMG_W-1 does not fit the pixel counter width");
    end
    if ((IMG_H < 1) || (64'(IMG_H) > CNT_LIM)) begin : g_bad_img_h
        $error("IMG_H-1 does not fit the pixel counter width");
    end

    seq_state_e       state_r;
    logic [CNT_W-1:0] x_r;
    logic [CNT_W-1:0] y_r;
    logic [PX_W-1:0]  px_cnt_r;
    vec3_t            p00_r;
    vec3_t            du_r;
    vec3_t            dv_r;
    vec3_t            cc_r;
    vec3_t            rgu_origin_s;
    vec3_t            rgu_dir_s;
    vec3_t            ray_origin_r;
    vec3_t            ray_dir_r;
    logic [PX_W-1:0]  ray_px_r;
    logic             ray_valid_r;
    logic             ray_last_r;
    logic             busy_r;
    logic             done_r;
    logic             load_s;
    logic             accept_s;
    logic             at_end_s;

    rt_rgu u_rgu (
        .pixel_00_loc  (p00_r),
        .pixel_delta_u (du_r),
        .pixel_delta_v (dv_r),
        .camera_center (cc_r),
        .x             (x_r),
        .y             (y_r),
        .ray_origin    (rgu_origin_s),
        .ray_dir       (rgu_dir_s)
    );

    // Output-stage handshake decode and end-of-frame detection.
    always_comb begin
        load_s   = (~ray_valid_r) | ray_if.ray_ready_i;
        accept_s = ray_valid_r & ray_if.ray_ready_i;
        at_end_s = (x_r == X_MAX) && (y_r == Y_MAX);
    end

    // Sequencer FSM with scan counters, camera shadow registers and ray output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            x_r          <= '0;
            y_r          <= '0;
            px_cnt_r     <= '0;
            p00_r        <= '0;
            du_r         <= '0;
            dv_r         <= '0;
            cc_r         <= '0;
            ray_origin_r <= '0;
            ray_dir_r    <= '0;
            ray_px_r     <= '0;
            ray_valid_r  <= 1'b0;
            ray_last_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else if (abort_i) begin
            state_r     <= ST_IDLE;
            ray_valid_r <= 1'b0;
            ray_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_i) begin
                        state_r  <= ST_RUN;
                        busy_r   <= 1'b1;
                        p00_r    <= pixel_00_loc_i;
                        du_r     <= pixel_delta_u_i;
                        dv_r     <= pixel_delta_v_i;
                        cc_r     <= camera_center_i;
                        x_r      <= '0;
                        y_r      <= '0;
                        px_cnt_r <= '0;
                    end
                end
                ST_RUN: begin
                    if (load_s) begin
                        ray_valid_r  <= 1'b1;
                        ray_origin_r <= rgu_origin_s;
                        ray_dir_r    <= rgu_dir_s;
                        ray_px_r     <= px_cnt_r;
                        ray_last_r   <= at_end_s;
                        if (at_end_s) begin
                            state_r <= ST_DRAIN;
                        end else begin
                            px_cnt_r <= px_cnt_r + PX_W'(1);
                            if (x_r == X_MAX) begin
                                x_r <= '0;
                                y_r <= y_r + CNT_W'(1);
                            end else begin
                                x_r <= x_r + CNT_W'(1);
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    // Only the final beat remains; its acceptance ends the frame.
                    if (accept_s) begin
                        state_r     <= ST_IDLE;
                        ray_valid_r <= 1'b0;
                        ray_last_r  <= 1'b0;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    ray_valid_r <= 1'b0;
                    ray_last_r  <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign ray_if.ray_valid_o  = ray_valid_r;
    assign ray_if.ray_origin_o = ray_origin_r;
    assign ray_if.ray_dir_o    = ray_dir_r;
    assign ray_if.ray_px_o     = ray_px_r;
    assign ray_if.ray_last_o   = ray_last_r;
    assign busy_o              = busy_r;
    assign done_o              = done_r;

`ifdef RT_SEQ_PERF_EN
    logic [31:0] perf_cycles_r;
    logic [31:0] perf_stalls_r;

    // Saturating busy and stall counters; cleared by an accepted start, frozen when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles_r <= 32'd0;
            perf_stalls_r <= 32'd0;
        end else if ((state_r == ST_IDLE) && start_i && !abort_i) begin
            perf_cycles_r <= 32'd0;
            perf_stalls_r <= 32'd0;
        end else begin
            if (busy_r && (perf_cycles_r != 32'hFFFF_FFFF)) begin
                perf_cycles_r <= perf_cycles_r + 32'd1;
            end
            if (ray_valid_r && !ray_if.ray_ready_i && (perf_stalls_r != 32'hFFFF_FFFF)) begin
                perf_stalls_r <= perf_stalls_r + 32'd1;
            end
        end
    end

    assign perf_cycles_o = perf_cycles_r;
    assign perf_stalls_o = perf_stalls_r;
`endif

endmodule
